// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: converts the control FSM's fetch/load/store requests into a
// handshaked access on a unified memory port with variable latency. Handles
// byte enables, store lane replication, load extension, misalignment and
// timeout errors, and stalls the FSM until the access completes.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_fetch,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   // Last wait-counter value before giving up. The counter holds the number
   // of cycles spent since issue, REQ being cycle 0.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      RESP,
      ERR
   } state_t;

   state_t      state_reg, state_next;
   logic [7:0]  cnt_reg, cnt_next;

   // Latched request attributes needed after acceptance.
   logic        fetch_reg;
   logic        we_reg;
   logic [2:0]  funct3_reg;
   logic [1:0]  off_reg;
   logic [31:0] mem_addr_reg;
   logic [3:0]  mem_be_reg;
   logic [31:0] mem_wdata_reg;
   logic [31:0] rdata_reg;

   // Decode of the incoming request (only meaningful while IDLE).
   logic [1:0]  req_size;      // 0 = byte, 1 = half, 2 = word
   logic        req_code_ok;
   logic        req_aligned;
   logic [3:0]  req_be;
   logic [31:0] req_wd;

   // Load extension of the returned word.
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;

   // FSM side controls.
   logic        accept;
   logic        capture;

   // Size and legality decode of the incoming request.
   always_comb begin
      req_size    = 2'd2;
      req_code_ok = 1'b1;
      if (!req_fetch) begin
         case (req_funct3)
            3'b000: req_size = 2'd0;
            3'b001: req_size = 2'd1;
            3'b010: req_size = 2'd2;
            3'b100: begin
               req_size    = 2'd0;
               req_code_ok = !req_we;
            end
            3'b101: begin
               req_size    = 2'd1;
               req_code_ok = !req_we;
            end
            default: req_code_ok = 1'b0;
         endcase
      end
   end

   // Alignment, byte enables and lane-replicated store data for the request.
   always_comb begin
      req_aligned = 1'b1;
      req_be      = 4'b1111;
      req_wd      = req_wdata;
      case (req_size)
         2'd0: begin
            req_be = 4'b0001 << req_addr[1:0];
            req_wd = {4{req_wdata[7:0]}};
         end
         2'd1: begin
            req_aligned = !req_addr[0];
            req_be      = 4'b0011 << req_addr[1:0];
            req_wd      = {2{req_wdata[15:0]}};
         end
         default: begin
            req_aligned = (req_addr[1:0] == 2'b00);
         end
      endcase
   end

   // Lane select and sign/zero extension of the memory read word.
   always_comb begin
      case (off_reg)
         2'd0:    byte_sel = mem_rdata[7:0];
         2'd1:    byte_sel = mem_rdata[15:8];
         2'd2:    byte_sel = mem_rdata[23:16];
         default: byte_sel = mem_rdata[31:24];
      endcase
      half_sel = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      load_ext = mem_rdata;
      if (!fetch_reg) begin
         case (funct3_reg)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = mem_rdata;
         endcase
      end
   end

   // Next-state logic and per-state control outputs.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      stall      = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      mem_en     = 1'b0;
      accept     = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            stall    = req_valid;
            cnt_next = 8'd0;
            if (req_valid) begin
               accept     = 1'b1;
               state_next = (req_code_ok && req_aligned) ? REQ : ERR;
            end
         end
         REQ: begin
            mem_en   = 1'b1;
            stall    = 1'b1;
            cnt_next = 8'd1;
            if (mem_ack) begin
               capture    = 1'b1;
               state_next = RESP;
            end else begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            mem_en   = 1'b1;
            stall    = 1'b1;
            cnt_next = cnt_reg + 8'd1;
            // An ack arriving in the last allowed cycle still wins.
            if (mem_ack) begin
               capture    = 1'b1;
               state_next = RESP;
            end else if (cnt_reg >= TIMEOUT_LAST) begin
               state_next = ERR;
            end
         end
         RESP: begin
            done       = 1'b1;
            cnt_next   = 8'd0;
            state_next = IDLE;
         end
         ERR: begin
            done       = 1'b1;
            err        = 1'b1;
            cnt_next   = 8'd0;
            state_next = IDLE;
         end
         default: begin
            cnt_next   = 8'd0;
            state_next = IDLE;
         end
      endcase
   end

   // State register and wait counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= 8'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Request latch, memory-port drive registers and load result register.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_reg     <= 1'b0;
         we_reg        <= 1'b0;
         funct3_reg    <= 3'd0;
         off_reg       <= 2'd0;
         mem_addr_reg  <= 32'd0;
         mem_be_reg    <= 4'd0;
         mem_wdata_reg <= 32'd0;
         rdata_reg     <= 32'd0;
      end else begin
         if (accept) begin
            fetch_reg     <= req_fetch;
            we_reg        <= req_we && !req_fetch;
            funct3_reg    <= req_funct3;
            off_reg       <= req_addr[1:0];
            mem_addr_reg  <= {req_addr[31:2], 2'b00};
            mem_be_reg    <= req_be;
            mem_wdata_reg <= req_wd;
         end
         // Stores leave the previous load result in place.
         if (capture && !we_reg) begin
            rdata_reg <= load_ext;
         end
      end
   end

   assign mem_we    = mem_en && we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_be    = mem_be_reg;
   assign mem_wdata = mem_wdata_reg;
   assign rdata     = rdata_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench. The driver computes each expected
// response from a byte-level memory model and pushes it to a queue; a
// monitor pops and compares whenever the DUT raises done, and checks the
// memory port while mem_en is high. A responder acks after a chosen delay.
module tb_mem_access_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_fetch;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   mem_access_ctrl #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_fetch (req_fetch),
      .req_we    (req_we),
      .req_funct3(req_funct3),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .stall     (stall),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          no_acc;
      bit          we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      bit          err;
      bit          chk_rd;
      logic [31:0] rd;
      int          done_cyc;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] phys[16];   // memory seen by the DUT, written through the port
   logic [31:0] refm[16];   // reference memory, written by the model
   int          ack_delay = 0;
   bit          force_ack = 1'b0;
   bit          skip_mon  = 1'b0;
   logic [31:0] last_rd   = 32'd0;
   bit          rd_known  = 1'b1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Memory responder: acks ack_delay cycles after mem_en rises.
   initial begin
      int k;
      k = 0;
      mem_ack   = 1'b0;
      mem_rdata = 32'd0;
      forever begin
         @(negedge clk);
         if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
         end else if (mem_en) begin
            if (k == ack_delay) begin
               mem_ack   = 1'b1;
               mem_rdata = phys[mem_addr[5:2]];
               if (mem_we)
                  for (int b = 0; b < 4; b++)
                     if (mem_be[b]) phys[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            end else begin
               mem_ack   = 1'b0;
               mem_rdata = $urandom;
            end
            k++;
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            k = 0;
         end
      end
   end

   // Monitor: port checks while mem_en, scoreboard pop on done.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mem_en && !skip_mon) begin
            if (sbq.size() == 0 || sbq[0].no_acc) begin
               checks++;
               errors++;
               $display("FAIL mem_en actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
               chk("mem_we", 32'(mem_we), 32'(sbq[0].we));
               chk("mem_addr", mem_addr, sbq[0].addr);
               chk("mem_be", 32'(mem_be), 32'(sbq[0].be));
               if (sbq[0].we) chk("mem_wdata", mem_wdata, sbq[0].wd);
               chk("stall_busy", 32'(stall), 32'd1);
            end
         end
         if (done) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL done actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
               e = sbq.pop_front();
               chk("err", 32'(err), 32'(e.err));
               if (e.chk_rd) chk("rdata", rdata, e.rd);
               chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
               chk("stall_done", 32'(stall), 32'd0);
            end
         end
      end
   end

   // Issue one request, push its expected outcome, wait for done.
   task automatic do_req(input bit f, input bit we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int w);
      exp_t        e;
      int          size;
      int          off;
      bit          ok;
      bit          seen;
      logic [31:0] v;
      logic [31:0] ba;
      @(posedge clk);
      #1;
      req_fetch  = f;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      req_valid  = 1'b1;
      ack_delay  = w;
      off  = int'(a[1:0]);
      size = 0;
      if (f) size = 4;
      else if (f3 == 3'b000 || f3 == 3'b100) size = 1;
      else if (f3 == 3'b001 || f3 == 3'b101) size = 2;
      else if (f3 == 3'b010) size = 4;
      ok = (size != 0) && !(we && f3[2]);
      if (ok) ok = ((off % size) == 0);
      e.no_acc = !ok;
      e.we     = we;
      e.addr   = {a[31:2], 2'b00};
      e.be     = (size == 0) ? 4'd0 : 4'(((1 << size) - 1) << off);
      e.wd     = 32'd0;
      if (size != 0)
         for (int b = 0; b < 4; b++) e.wd[8*b +: 8] = wd[8*(b % size) +: 8];
      e.chk_rd = rd_known;
      e.rd     = last_rd;
      if (!ok) begin
         e.err      = 1'b1;
         e.done_cyc = cyc + 1;
      end else if (w >= TO) begin
         e.err      = 1'b1;
         e.done_cyc = cyc + 1 + TO;
      end else begin
         e.err      = 1'b0;
         e.done_cyc = cyc + 2 + w;
         if (we) begin
            for (int i = 0; i < size; i++) begin
               ba = a + 32'(i);
               refm[ba[5:2]][8*ba[1:0] +: 8] = wd[8*i +: 8];
            end
            e.chk_rd = 1'b0;
            rd_known = 1'b0;
         end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) begin
               ba = a + 32'(i);
               v[8*i +: 8] = refm[ba[5:2]][8*ba[1:0] +: 8];
            end
            if (!f && !f3[2] && size == 1 && v[7])  v[31:8]  = '1;
            if (!f && !f3[2] && size == 2 && v[15]) v[31:16] = '1;
            e.chk_rd = 1'b1;
            e.rd     = v;
            last_rd  = v;
            rd_known = 1'b1;
         end
      end
      sbq.push_back(e);
      $display("req fetch=%0d we=%0d f3=%0d addr=%h wdata=%h ackdly=%0d exp_err=%0d exp_rd=%h",
               f, we, f3, a, wd, w, e.err, e.rd);
      @(negedge clk);
      chk("stall_accept", 32'(stall), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         // Junk requests while busy must be ignored.
         req_valid  = 1'($urandom_range(0, 1));
         req_addr   = $urandom;
         req_funct3 = 3'($urandom_range(0, 7));
         req_we     = 1'($urandom_range(0, 1));
      end
      req_valid = 1'b0;
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_wait actual=none expected=done within 40 cycles");
      end
   endtask

   // Outputs that must all read zero after reset.
   task automatic chk_idle_zero(input string tag);
      chk({tag, "_stall"}, 32'(stall), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_mem_be"}, 32'(mem_be), 32'd0);
      chk({tag, "_mem_addr"}, mem_addr, 32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      chk({tag, "_rdata"}, rdata, 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          f;
      bit          we;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      int          w;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_fetch  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      for (int i = 0; i < 16; i++) begin
         phys[i] = $urandom;
         refm[i] = phys[i];
      end
      phys[4] = 32'h0050_0093;
      refm[4] = 32'h0050_0093;
      phys[0] = 32'h8011_2233;
      refm[0] = 32'h8011_2233;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_idle_zero("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk_idle_zero("post_reset");

      // Directed cases.
      do_req(1'b1, 1'b0, 3'b000, 32'h0000_0010, 32'd0, 0);
      do_req(1'b0, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 3);
      do_req(1'b0, 1'b0, 3'b100, 32'h0000_0103, 32'd0, 3);
      do_req(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 2);
      do_req(1'b0, 1'b0, 3'b010, 32'h0000_0105, 32'd0, 0);
      do_req(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0000_0055, 0);
      do_req(1'b0, 1'b0, 3'b010, 32'h0000_0008, 32'd0, 99);
      do_req(1'b0, 1'b0, 3'b010, 32'h0000_0008, 32'd0, TO - 1);
      do_req(1'b0, 1'b0, 3'b001, 32'h0000_0202, 32'd0, 1);

      // Reset in the second WAIT cycle, then a stray ack.
      @(posedge clk);
      #1;
      skip_mon   = 1'b1;
      ack_delay  = 99;
      req_fetch  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_0020;
      req_valid  = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      force_ack = 1'b1;
      @(negedge clk);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(posedge clk);
      #1;
      force_ack = 1'b0;
      @(negedge clk);
      chk_idle_zero("mid_reset");
      skip_mon = 1'b0;
      last_rd  = 32'd0;
      rd_known = 1'b1;
      $display("mid-transaction reset applied");
      do_req(1'b1, 1'b0, 3'b000, 32'h0000_0010, 32'd0, 1);
      do_req(1'b0, 1'b0, 3'b010, 32'h0000_0008, 32'd0, 99);

      // Randomized traffic.
      for (int t = 0; t < 150; t++) begin
         f  = ($urandom_range(0, 5) == 0);
         we = f ? 1'b0 : ($urandom_range(0, 2) == 0);
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         wd = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (f || f3[1:0] == 2'b10 || f3[1:0] == 2'b11) a[1:0] = 2'b00;
            else if (f3[1:0] == 2'b01) a[0] = 1'b0;
         end
         w = ($urandom_range(0, 7) == 0) ? TO + int'($urandom_range(0, 2)) : int'($urandom_range(0, TO - 1));
         do_req(f, we, f3, a, wd, w);
      end

      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
